// File: rtl/sop_circuit.sv
// rtl/sop_circuit.sv - registered 4-input sum-of-products evaluator with reprogrammable minterm mask
module sop_circuit #(
  parameter logic [15:0] MINTERMS = 16'hF2E2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        cfg_we,
  input  logic [15:0] cfg_mask,
  output logic        F,
  output logic [15:0] mask_q
);

  logic [3:0] idx;
  logic       f_next;

  // A is the most significant index bit, D the least.
  assign idx    = {A, B, C, D};
  assign f_next = mask_q[idx];

  // Mask register: reset restores the default function and beats a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= MINTERMS;
    end else if (cfg_we) begin
      mask_q <= cfg_mask;
    end
  end

  // Output register: f_next is built from the pre-edge mask, so a write only
  // changes F from the edge after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      F <= 1'b0;
    end else begin
      F <= f_next;
    end
  end

endmodule

// File: tb/tb_sop_circuit.sv
// tb/tb_sop_circuit.sv - directed self-checking bench for sop_circuit
module tb_sop_circuit;

  logic        clk;
  logic        rst_n;
  logic        A, B, C, D;
  logic        cfg_we;
  logic [15:0] cfg_mask;
  logic        F;
  logic [15:0] mask_q;

  int checks;
  int errors;

  // Hand-derived truth table of A&B | ~C&D | ~A&B&C, indexed by {A,B,C,D}.
  logic exp_default [16] = '{1'b0, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b1};

  sop_circuit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .cfg_we   (cfg_we),
    .cfg_mask (cfg_mask),
    .F        (F),
    .mask_q   (mask_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idx(input logic [3:0] v);
    {A, B, C, D} = v;
  endtask

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_mask = 16'h0000;
    set_idx(4'b1111);
    step();
    checks++;
    if (F !== 1'b0) begin
      errors++;
      $display("FAIL reset_F got %b want 0", F);
    end
    checks++;
    if (mask_q !== 16'hF2E2) begin
      errors++;
      $display("FAIL reset_mask got %h want f2e2", mask_q);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      set_idx(i[3:0]);
      step();
      checks++;
      if (F !== exp_default[i]) begin
        errors++;
        $display("FAIL %s idx=%0d got %b want %b", tag, i, F, exp_default[i]);
      end
    end
  endtask

  task automatic test_spot();
    logic [3:0] vec [4] = '{4'b1100, 4'b0001, 4'b0110, 4'b1010};
    logic       exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_idx(vec[i]);
      step();
      checks++;
      if (F !== exp[i]) begin
        errors++;
        $display("FAIL spot %b got %b want %b", vec[i], F, exp[i]);
      end
    end
  endtask

  task automatic test_reprogram();
    cfg_we = 1'b1;
    cfg_mask = 16'h0001;
    set_idx(4'b0000);
    step();
    checks++;
    if (F !== 1'b0) begin
      errors++;
      $display("FAIL reprog_old_mask got %b want 0", F);
    end
    checks++;
    if (mask_q !== 16'h0001) begin
      errors++;
      $display("FAIL reprog_mask got %h want 0001", mask_q);
    end
    cfg_we = 1'b0;
    cfg_mask = 16'hABCD;
    set_idx(4'b0000);
    step();
    checks++;
    if (F !== 1'b1) begin
      errors++;
      $display("FAIL reprog_idx0 got %b want 1", F);
    end
    checks++;
    if (mask_q !== 16'h0001) begin
      errors++;
      $display("FAIL reprog_hold got %h want 0001", mask_q);
    end
    set_idx(4'b1111);
    step();
    checks++;
    if (F !== 1'b0) begin
      errors++;
      $display("FAIL reprog_idx15 got %b want 0", F);
    end
    set_idx(4'b1100);
    step();
    checks++;
    if (F !== 1'b0) begin
      errors++;
      $display("FAIL reprog_idx12 got %b want 0", F);
    end
  endtask

  task automatic test_reset_vs_write();
    rst_n = 1'b0;
    cfg_we = 1'b1;
    cfg_mask = 16'hFFFF;
    set_idx(4'b1111);
    step();
    checks++;
    if (mask_q !== 16'hF2E2) begin
      errors++;
      $display("FAIL rst_vs_we_mask got %h want f2e2", mask_q);
    end
    checks++;
    if (F !== 1'b0) begin
      errors++;
      $display("FAIL rst_vs_we_F got %b want 0", F);
    end
    rst_n = 1'b1;
    cfg_we = 1'b0;
  endtask

  task automatic test_midrun_reset();
    cfg_we = 1'b1;
    cfg_mask = 16'hFFFF;
    set_idx(4'b0000);
    step();
    cfg_we = 1'b0;
    set_idx(4'b0000);
    step();
    checks++;
    if (F !== 1'b1) begin
      errors++;
      $display("FAIL midrun_newmask got %b want 1", F);
    end
    rst_n = 1'b0;
    set_idx(4'b1111);
    step();
    checks++;
    if (F !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst_F got %b want 0", F);
    end
    checks++;
    if (mask_q !== 16'hF2E2) begin
      errors++;
      $display("FAIL midrun_rst_mask got %h want f2e2", mask_q);
    end
    rst_n = 1'b1;
    test_default_sweep("midrun_sweep");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_mask = 16'h0000;
    set_idx(4'b0000);
    #1;
    test_reset();
    test_default_sweep("default_sweep");
    test_spot();
    test_reprogram();
    test_reset_vs_write();
    test_spot();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
